sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Shares the single SDRAM command port between the ROM-download write channel (ioctl bytes for the wave-sample index) and the sound core's wave-sample read channel. Holds one pending request per channel, grants by fixed write priority with read aging, drives the SDRAM request/acknowledge handshake, and back-pressures the download stream via a wait output. Sits between hps_io/the sound core and the sdram controller, replacing the combinational address/command mux.

## Interface
- WAVE_INDEX, 2: ioctl_index value whose bytes are written to SDRAM.
- AGE_MAX, 4: consecutive write grants after which a pending read wins the next slot.
- TIMEOUT, 255: clk_sys cycles allowed between mem_req and mem_ack.

- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_wr  in  1  download byte strobe, one cycle.
- dl_index  in  8  download index.
- dl_addr  in  25  download byte address.
- dl_data  in  8  download byte.
- dl_wait  out  1  back-pressure to hps_io.
- wave_rd  in  1  read request strobe, one cycle.
- wave_addr  in  20  word address.
- wave_data  out  16  read data, held until next completion.
- wave_valid  out  1  one-cycle pulse with new wave_data.
- mem_req  out  1  one-cycle command strobe.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  25  byte address (reads: {4'b0, wave_addr, 1'b0}).
- mem_wdata  out  8  write byte.
- mem_ack  in  1  one-cycle completion (write done or read data valid).
- mem_rdata  in  16  read word, valid with mem_ack.
- err_timeout  out  1  sticky timeout flag.

## Operation
- Write capture: dl_wr with dl_index==WAVE_INDEX latches addr/data into wr_pend, sets dl_wait next cycle. Other indexes ignored. dl_wr while wr_pend set: protocol violation, byte dropped.
- Read capture: wave_rd latches wave_addr into rd_pend. wave_rd while rd_pend set overwrites the address (latest wins).
- States: IDLE, ISSUE, WAIT.
  - IDLE: if wr_pend and (!rd_pend or age<AGE_MAX) -> grant write, age+=1 (saturating); else if rd_pend -> grant read, age=0. Grant -> ISSUE.
  - ISSUE: mem_req=1 one cycle with granted command -> WAIT; timeout counter cleared.
  - WAIT: mem_ack -> clear granted pend; read: wave_data<=mem_rdata, wave_valid pulse; write: dl_wait drops. -> IDLE. Counter reaching TIMEOUT -> err_timeout=1, granted pend cleared (write releases dl_wait, read produces no wave_valid) -> IDLE.
- Capture in the same cycle a pend clears is legal; new request is kept.
- mem_ack outside WAIT ignored.
- age resets to 0 whenever no write is pending.
- err_timeout clears only by reset.

## Timing
- Reset values: dl_wait=0, wave_data=0, wave_valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_timeout=0; state IDLE, pends clear, age=0.
- Request strobe at cycle N -> pend visible N+1 -> grant in IDLE N+1 -> mem_req at N+2.
- mem_ack at cycle M -> wave_valid/dl_wait low at M+1; next mem_req no earlier than M+2.
- All outputs registered.
- Reset asserted mid-transaction: aborts immediately; a late mem_ack after reset release is ignored (state IDLE).

## Configuration
- SDRAM_ARB_CACHE_EN defined: keeps last completed read word address+data. wave_rd hitting that address (and no write completed since) returns wave_valid one cycle after the strobe with cached data, no SDRAM command. Any completed write invalidates the cache.
- Undefined: every read goes to SDRAM.

## Test plan
- Reset then write: dl_wr, index 2, addr 0x00010, data 0xA5 -> dl_wait high next cycle, mem_req with mem_we=1, addr 0x00010, wdata 0xA5; ack -> dl_wait low next cycle.
- Index filter: dl_wr with index 0 -> no mem_req, dl_wait stays 0.
- Read: wave_rd addr 0x01234 -> mem_req mem_we=0 addr 0x0002468; ack with 0xBEEF -> wave_valid one cycle, wave_data=0xBEEF held.
- Aging: read pending during 5 back-to-back writes, AGE_MAX=4 -> grant order W,W,W,W,R,W.
- Timeout: no mem_ack for 255 cycles -> err_timeout=1, state IDLE, next request serviced normally.
- Cache (SDRAM_ARB_CACHE_EN): repeat read 0x01234 -> wave_valid one cycle after strobe, 0xBEEF, no mem_req; after one write, same read issues mem_req.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM command port between the ROM-download write channel
// and the sound core's wave-sample read channel. One pending request is held
// per channel. Writes win by default, but a waiting read is forced through
// after AGE_MAX consecutive write grants. Every command is a one-cycle mem_req
// followed by a wait for mem_ack, bounded by TIMEOUT cycles.
//
// Optional feature macro: SDRAM_ARB_CACHE_EN
//   When defined, the last completed read word (address + data) is kept. A
//   wave_rd to that address is answered one cycle later without touching the
//   SDRAM. Any finished write invalidates the entry.

module sdram_port_arbiter #(
   parameter logic [7:0] WAVE_INDEX = 8'd2,
   parameter int         AGE_MAX    = 4,
   parameter int         TIMEOUT    = 255
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_wr,
   input  logic [7:0]  dl_index,
   input  logic [24:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   input  logic        wave_rd,
   input  logic [19:0] wave_addr,
   output logic [15:0] wave_data,
   output logic        wave_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        err_timeout
);

   // Counter widths: age saturates at AGE_MAX, timer counts 0..TIMEOUT-1
   localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(AGE_MAX);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t            state_reg, state_next;

   // Pending requests
   logic              wr_pend_reg, wr_pend_next;
   logic [24:0]       wr_addr_reg, wr_addr_next;
   logic [7:0]        wr_data_reg, wr_data_next;
   logic              rd_pend_reg, rd_pend_next;
   logic [19:0]       rd_addr_reg, rd_addr_next;

   // Arbitration / transaction bookkeeping
   logic [AGE_W-1:0]  age_reg, age_next;
   logic              gnt_we_reg, gnt_we_next;
   logic [TMR_W-1:0]  tmr_reg, tmr_next;

   // Registered outputs
   logic [15:0]       wave_data_reg, wave_data_next;
   logic              wave_valid_reg, wave_valid_next;
   logic              mem_req_reg, mem_req_next;
   logic              mem_we_reg, mem_we_next;
   logic [24:0]       mem_addr_reg, mem_addr_next;
   logic [7:0]        mem_wdata_reg, mem_wdata_next;
   logic              err_timeout_reg, err_timeout_next;

   // End-of-transaction decode for the granted channel
   logic              wait_ack;
   logic              wait_tmo;
   logic              wr_clr;
   logic              rd_clr;
   logic              wr_take;
   logic              rd_take;
   logic              cache_hit;
   logic [15:0]       cache_word;

   assign wait_ack = (state_reg == ST_WAIT) && mem_ack;
   assign wait_tmo = (state_reg == ST_WAIT) && !mem_ack && (tmr_reg == TMR_LAST);
   assign wr_clr   = (wait_ack || wait_tmo) && gnt_we_reg;
   assign rd_clr   = (wait_ack || wait_tmo) && !gnt_we_reg;

   // A download byte is accepted when the slot is free or being freed this
   // cycle; a byte arriving while the slot is still busy is dropped.
   assign wr_take  = dl_wr && (dl_index == WAVE_INDEX) && (!wr_pend_reg || wr_clr);
   assign rd_take  = wave_rd && !cache_hit;

`ifdef SDRAM_ARB_CACHE_EN
   logic              cache_valid_reg, cache_valid_next;
   logic [19:0]       cache_addr_reg, cache_addr_next;
   logic [15:0]       cache_data_reg, cache_data_next;

   // A hit is only taken while no read is outstanding, so it can never collide
   // with a completing SDRAM read on wave_data, and never while a write lands.
   assign cache_hit  = wave_rd && cache_valid_reg && !rd_pend_reg && !wr_clr &&
                       (wave_addr == cache_addr_reg);
   assign cache_word = cache_data_reg;

   // Cache fill on read completion, invalidate on any finished write
   always_comb begin
      cache_valid_next = cache_valid_reg;
      cache_addr_next  = cache_addr_reg;
      cache_data_next  = cache_data_reg;
      if (wait_ack && !gnt_we_reg) begin
         cache_valid_next = 1'b1;
         cache_addr_next  = mem_addr_reg[20:1];
         cache_data_next  = mem_rdata;
      end
      if (wr_clr) begin
         cache_valid_next = 1'b0;
      end
   end

   // Cache registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cache_valid_reg <= 1'b0;
         cache_addr_reg  <= '0;
         cache_data_reg  <= '0;
      end else begin
         cache_valid_reg <= cache_valid_next;
         cache_addr_reg  <= cache_addr_next;
         cache_data_reg  <= cache_data_next;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_word = 16'h0000;
`endif

   // Arbitration FSM, request capture and output next-state
   always_comb begin
      state_next       = state_reg;
      wr_pend_next     = wr_pend_reg;
      wr_addr_next     = wr_addr_reg;
      wr_data_next     = wr_data_reg;
      rd_pend_next     = rd_pend_reg;
      rd_addr_next     = rd_addr_reg;
      age_next         = age_reg;
      gnt_we_next      = gnt_we_reg;
      tmr_next         = tmr_reg;
      wave_data_next   = wave_data_reg;
      wave_valid_next  = 1'b0;
      mem_req_next     = 1'b0;
      mem_we_next      = mem_we_reg;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      err_timeout_next = err_timeout_reg;

      case (state_reg)
         ST_IDLE: begin
            if (wr_pend_reg && (!rd_pend_reg || (age_reg < AGE_LIM))) begin
               gnt_we_next    = 1'b1;
               mem_req_next   = 1'b1;
               mem_we_next    = 1'b1;
               mem_addr_next  = wr_addr_reg;
               mem_wdata_next = wr_data_reg;
               if (age_reg < AGE_LIM) begin
                  age_next = age_reg + AGE_W'(1);
               end
               state_next     = ST_ISSUE;
            end else if (rd_pend_reg) begin
               gnt_we_next    = 1'b0;
               mem_req_next   = 1'b1;
               mem_we_next    = 1'b0;
               mem_addr_next  = {4'b0000, rd_addr_reg, 1'b0};
               age_next       = '0;
               state_next     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // mem_req is high during this cycle; start the ack timer
            tmr_next   = '0;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_ack) begin
               if (!gnt_we_reg) begin
                  wave_data_next  = mem_rdata;
                  wave_valid_next = 1'b1;
               end
               state_next = ST_IDLE;
            end else if (wait_tmo) begin
               err_timeout_next = 1'b1;
               state_next       = ST_IDLE;
            end else begin
               tmr_next = tmr_reg + TMR_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (cache_hit) begin
         wave_valid_next = 1'b1;
         wave_data_next  = cache_word;
      end

      // Clear first so that a same-cycle capture survives
      if (wr_clr) begin
         wr_pend_next = 1'b0;
      end
      if (wr_take) begin
         wr_pend_next = 1'b1;
         wr_addr_next = dl_addr;
         wr_data_next = dl_data;
      end
      if (rd_clr) begin
         rd_pend_next = 1'b0;
      end
      if (rd_take) begin
         rd_pend_next = 1'b1;
         rd_addr_next = wave_addr;
      end

      // Aging only spans an unbroken run of pending writes
      if (!wr_pend_reg) begin
         age_next = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         wr_pend_reg     <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         rd_pend_reg     <= 1'b0;
         rd_addr_reg     <= '0;
         age_reg         <= '0;
         gnt_we_reg      <= 1'b0;
         tmr_reg         <= '0;
         wave_data_reg   <= '0;
         wave_valid_reg  <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wr_pend_reg     <= wr_pend_next;
         wr_addr_reg     <= wr_addr_next;
         wr_data_reg     <= wr_data_next;
         rd_pend_reg     <= rd_pend_next;
         rd_addr_reg     <= rd_addr_next;
         age_reg         <= age_next;
         gnt_we_reg      <= gnt_we_next;
         tmr_reg         <= tmr_next;
         wave_data_reg   <= wave_data_next;
         wave_valid_reg  <= wave_valid_next;
         mem_req_reg     <= mem_req_next;
         mem_we_reg      <= mem_we_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         err_timeout_reg <= err_timeout_next;
      end
   end

   // dl_wait mirrors the write slot flop: high the cycle after capture,
   // low the cycle after the write finishes.
   assign dl_wait     = wr_pend_reg;
   assign wave_data   = wave_data_reg;
   assign wave_valid  = wave_valid_reg;
   assign mem_req     = mem_req_reg;
   assign mem_we      = mem_we_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign err_timeout = err_timeout_reg;

endmodule
